// File: rtl/argmax_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// argmax_pkg
// Shared constants and types for the serial argmax controller.
//   DATA_WIDTH_DEF / NUM_CLASSES_DEF / IDX_W_DEF / CNT_W_DEF : default sizing
//   PREDICT_W : width of the prediction word (index zero-extended)
//   state_e   : controller state encoding (ACCUM = 0, DONE = 1)
// -----------------------------------------------------------------------------
package argmax_pkg;

    localparam int DATA_WIDTH_DEF  = 29;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int IDX_W_DEF       = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int PREDICT_W       = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

endpackage : argmax_pkg

// File: rtl/argmax_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// argmax_seq_ctrl_if
// Score input stream and prediction output stream of the argmax controller.
//   in_valid / in_ready / in_data / in_last : one signed class score per beat
//   out_valid / out_ready / predict         : held prediction handshake
//   frames_done                             : completed-frame counter
//   frame_err                               : framing error for current predict
// Modports:
//   master : the side producing scores and consuming predictions
//   slave  : the argmax controller
// -----------------------------------------------------------------------------
interface argmax_seq_ctrl_if
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
);

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [PREDICT_W-1:0]         predict;
    logic [CNT_W-1:0]             frames_done;
    logic                         frame_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, predict, frames_done, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, predict, frames_done, frame_err
    );

endinterface : argmax_seq_ctrl_if

// File: rtl/argmax_seq_ctrl_cmp_step.sv
// -----------------------------------------------------------------------------
// argmax_cmp_step
// One combinational step of the argmax reduction. The same rule is used by the
// parallel comparator tree, so results can be cross-checked bit for bit.
//   cur_max / cur_idx : running maximum and its class index
//   first             : this is the first score of the frame (take it as-is)
//   new_score/new_idx : incoming score and its class index
//   nxt_max / nxt_idx : updated maximum and index (ties go to the new index)
// -----------------------------------------------------------------------------
module argmax_cmp_step
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] cur_max,
    input  logic        [IDX_W-1:0]      cur_idx,
    input  logic                         first,
    input  logic signed [DATA_WIDTH-1:0] new_score,
    input  logic        [IDX_W-1:0]      new_idx,
    output logic signed [DATA_WIDTH-1:0] nxt_max,
    output logic        [IDX_W-1:0]      nxt_idx
);

    logic take;

    // Signed >= so that equal scores resolve to the later class index.
    assign take    = first || (new_score >= cur_max);
    assign nxt_max = take ? new_score : cur_max;
    assign nxt_idx = take ? new_idx   : cur_idx;

endmodule : argmax_cmp_step

// File: rtl/argmax_seq_ctrl.sv
// -----------------------------------------------------------------------------
// argmax_seq_ctrl
// Serial argmax controller for the classifier output stage. Scores arrive one
// class per beat; a single shared signed compare step tracks the running
// maximum. At frame end the winning index is presented on a held valid/ready
// output; no beats are accepted while a prediction is pending.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low (0 = reset)
//   bus  : argmax_seq_ctrl_if.slave (score stream, prediction, counters)
// Optional feature (macro ARGMAX_ERRCHK_EN): in_last framing check. An early
// in_last ends the frame with frame_err=1; a full-count frame without in_last
// also sets frame_err. Without the macro in_last is ignored and frame_err=0.
// -----------------------------------------------------------------------------
module argmax_seq_ctrl
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    argmax_seq_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_e                       state_q, state_d;
    logic        [IDX_W-1:0]      idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic        [IDX_W-1:0]      best_q, best_d;
    logic        [IDX_W-1:0]      pred_q, pred_d;
    logic        [CNT_W-1:0]      frames_q, frames_d;
    logic                         err_q, err_d;

    logic                         in_ready_int;
    logic                         beat;
    logic                         last_beat;
    logic signed [DATA_WIDTH-1:0] step_max;
    logic        [IDX_W-1:0]      step_idx;

    argmax_cmp_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_cmp_step (
        .cur_max   (max_q),
        .cur_idx   (best_q),
        .first     (idx_q == '0),
        .new_score (bus.in_data),
        .new_idx   (idx_q),
        .nxt_max   (step_max),
        .nxt_idx   (step_idx)
    );

    // in_ready is gated by rst so nothing looks acceptable while held in reset.
    assign in_ready_int = rst && (state_q == ACCUM);
    assign beat         = bus.in_valid && in_ready_int;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        max_d     = max_q;
        best_d    = best_q;
        pred_d    = pred_q;
        frames_d  = frames_q;
        err_d     = err_q;
        last_beat = 1'b0;

        case (state_q)
            ACCUM: begin
                if (beat) begin
                    max_d  = step_max;
                    best_d = step_idx;
                    idx_d  = idx_q + 1'b1;
`ifdef ARGMAX_ERRCHK_EN
                    last_beat = (idx_q == LAST_IDX) || bus.in_last;
`else
                    last_beat = (idx_q == LAST_IDX);
`endif
                    if (last_beat) begin
                        // Prediction uses the post-update index of this beat.
                        pred_d   = step_idx;
                        frames_d = frames_q + 1'b1;
                        idx_d    = '0;
                        state_d  = DONE;
`ifdef ARGMAX_ERRCHK_EN
                        // Good framing means in_last exactly on the final count.
                        err_d = !((idx_q == LAST_IDX) && bus.in_last);
`endif
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ACCUM;
            idx_q    <= '0;
            max_q    <= '0;
            best_q   <= '0;
            pred_q   <= '0;
            frames_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            best_q   <= best_d;
            pred_q   <= pred_d;
            frames_q <= frames_d;
            err_q    <= err_d;
        end
    end

`ifndef ARGMAX_ERRCHK_EN
    // in_last has no function in this build.
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
`endif

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.predict     = PREDICT_W'(pred_q);
    assign bus.frames_done = frames_q;
    assign bus.frame_err   = err_q;

endmodule : argmax_seq_ctrl

// File: tb/tb_argmax_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_argmax_seq_ctrl
// Directed and randomized frames against an array-based argmax reference.
// -----------------------------------------------------------------------------
module tb_argmax_seq_ctrl;
    import argmax_pkg::*;

    localparam int DW = 29;
    localparam int NC = 10;
    localparam int IW = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    argmax_seq_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    argmax_seq_ctrl #(
        .DATA_WIDTH  (DW),
        .NUM_CLASSES (NC),
        .IDX_W       (IW),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    logic signed [DW-1:0] sc [NC];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: first score taken, later score replaces on >= (signed).
    function automatic int ref_argmax(input int n);
        int b = 0;
        for (int k = 1; k < n; k++)
            if (sc[k] >= sc[b]) b = k;
        return b;
    endfunction

    task automatic send_beat(input logic signed [DW-1:0] d, input logic last);
        int w;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_frame(input int last_pos, input bit pre_ready, input int hold,
                             input int gap_max, input string tag);
        int end_i;
        int exp_pred;
        bit exp_err;
`ifdef ARGMAX_ERRCHK_EN
        end_i   = (last_pos >= 0 && last_pos < NC - 1) ? last_pos : NC - 1;
        exp_err = (last_pos != NC - 1);
`else
        end_i   = NC - 1;
        exp_err = 1'b0;
`endif
        exp_pred   = ref_argmax(end_i + 1);
        exp_frames = (exp_frames + 1) % (1 << CW);
        bus.out_ready = pre_ready;
        for (int k = 0; k <= end_i; k++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (k == end_i) check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            send_beat(sc[k], (k == last_pos));
        end
        check({tag, "_valid"},  32'(bus.out_valid),   32'd1);
        check({tag, "_pred"},   bus.predict,          32'(exp_pred));
        check({tag, "_frames"}, 32'(bus.frames_done), 32'(exp_frames));
        check({tag, "_err"},    32'(bus.frame_err),   32'(exp_err));
        check({tag, "_rdy_done"}, 32'(bus.in_ready),  32'd0);
        if (!pre_ready) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_pred"},  bus.predict,        32'(exp_pred));
                check({tag, "_hold_err"},   32'(bus.frame_err), 32'(exp_err));
                check({tag, "_hold_rdy"},   32'(bus.in_ready),  32'd0);
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_accepted"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),    32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
        check({tag, "_predict"},   bus.predict,          32'd0);
        check({tag, "_frames"},    32'(bus.frames_done), 32'd0);
        check({tag, "_err"},       32'(bus.frame_err),   32'd0);
    endtask

    initial begin
        int v;
        int lp;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst0");
        rst = 1'b1;
        @(negedge clk);

        // Mixed-sign scores, class 2 wins.
        sc = '{29'sd5, -29'sd3, 29'sd100, 29'sd7, 29'sd0, 29'sd99, -29'sd100,
               29'sd1, 29'sd2, 29'sd3};
        run_frame(NC - 1, 1'b1, 0, 0, "t1");

        // All negative; -1 (0x1FFFFFFF) must beat -50 (0x1FFFFFCE).
        for (int k = 0; k < NC; k++) sc[k] = -29'sd50;
        sc[7] = -29'sd1;
        run_frame(NC - 1, 1'b1, 0, 1, "t2");

        // Equal maxima at classes 3 and 8: later index wins.
        for (int k = 0; k < NC; k++) sc[k] = '0;
        sc[3] = 29'sh0FFFFFFF;
        sc[8] = 29'sh0FFFFFFF;
        run_frame(NC - 1, 1'b0, 0, 0, "t3");

        // Back-pressure for 5 cycles, then an independent second frame.
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_frame(NC - 1, 1'b0, 5, 1, "t4a");
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_frame(NC - 1, 1'b1, 0, 0, "t4b");

        // Abort a frame with large scores by reset; the next frame must not see them.
        for (int k = 0; k < 4; k++) send_beat(29'sd1000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("rst_mid");
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NC; k++) sc[k] = DW'(k);
        sc[1] = 29'sd50;
        run_frame(NC - 1, 1'b1, 0, 0, "t5");

        // Reset while a prediction is pending drops it.
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_frame(NC - 1, 1'b0, 2, 0, "t6");
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        bus.out_ready = 1'b0;
        for (int k = 0; k < NC; k++) send_beat(sc[k], (k == NC - 1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("rst_done");
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_done_rdy", 32'(bus.in_ready), 32'd1);

`ifdef ARGMAX_ERRCHK_EN
        // Early in_last on idx 5 with the maximum at class 4.
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom_range(0, 1000));
        sc[4] = 29'sd5000;
        run_frame(5, 1'b1, 0, 0, "e1");
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_frame(NC - 1, 1'b1, 0, 0, "e2");
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom);
        run_frame(-1, 1'b0, 1, 0, "e3");
`endif

        // Randomized frames: wide scores or a narrow range to force ties.
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < NC; k++) begin
                if (f % 2 == 0) sc[k] = DW'($urandom);
                else begin
                    v = $urandom_range(0, 3);
                    sc[k] = DW'(v - 1);
                end
            end
            lp = NC - 1;
`ifdef ARGMAX_ERRCHK_EN
            case ($urandom_range(0, 3))
                0: lp = $urandom_range(0, NC - 2);
                1: lp = -1;
                default: lp = NC - 1;
            endcase
`endif
            run_frame(lp, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 2, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_argmax_seq_ctrl

// File: doc/argmax_seq_ctrl.md
Name: argmax_seq_ctrl

Overview:
- Serial argmax controller for the classifier output stage.
- Accepts one class score per beat from the final layer over a valid/ready stream and runs a single shared signed compare unit across the frame. Presents the winning class index on a held valid/ready output.
- Replaces the 10-wide parallel comparator tree where area matters; the output encoding matches it (4-bit index, zero-extended to 32 bits).

Parameters:
- DATA_WIDTH, 29, score width, two's complement.
- NUM_CLASSES, 10, beats per frame (2..16).
- IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_CLASSES.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  score beat valid.
- in_ready  out  1  controller can accept a beat.
- in_data  in  DATA_WIDTH  signed class score; beat k is class k.
- in_last  in  1  final-beat marker (checked only with ARGMAX_ERRCHK_EN).
- out_valid  out  1  prediction available.
- out_ready  in  1  consumer accepts prediction.
- predict  out  32  {zeros, best index}.
- frames_done  out  CNT_W  completed frames, wraps modulo 2**CNT_W.
- frame_err  out  1  framing error flag for the current prediction.

Behaviour:
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst=0, async):
  - state=ACCUM, idx=0, max=0, best=0.
  - predict=0, out_valid=0, frames_done=0, frame_err=0.
  - in_ready=0 while rst=0.
- Beat transfer: in_valid && in_ready at a rising edge.
- On each beat in ACCUM:
  - If idx==0, or in_data >= max (signed compare, full DATA_WIDTH), then max<=in_data and best<=idx.
  - Ties therefore resolve to the later index.
  - Then idx<=idx+1.
- Frame end is the beat with idx==NUM_CLASSES-1. On it:
  - The compare update applies first, and predict<={0,best_next}.
  - frames_done+=1, idx<=0, go to DONE.
- Latency: out_valid rises the cycle after the final beat is accepted.
- In DONE:
  - predict and frame_err are held stable.
  - Leave DONE on out_valid && out_ready, back to ACCUM. in_ready rises the next cycle (one bubble per frame).
- in_valid=0 in ACCUM: hold all state; gaps between beats are allowed.
- out_ready high before out_valid has no effect.
- frames_done wraps from 2**CNT_W-1 to 0 without any flag.
- Reset mid-frame: partial frame discarded, frames_done cleared.
- Reset in DONE: pending prediction dropped.
- Never simultaneously accept a beat and issue a prediction (in_ready=0 in DONE).

Optional Feature:
- Macro ARGMAX_ERRCHK_EN.
- Defined:
  - in_last asserted on a beat with idx<NUM_CLASSES-1 ends the frame early. The argmax covers only the beats received; the controller enters DONE with frame_err=1.
  - Final count beat without in_last: frame ends normally with frame_err=1.
  - Correct framing: frame_err=0.
  - frame_err updates with predict.
- Undefined: in_last ignored, frame_err tied 0, no early termination.

Decomposition:
- Package argmax_pkg holds:
  - DATA_WIDTH/NUM_CLASSES/IDX_W defaults.
  - state encoding (ACCUM=1'b0, DONE=1'b1).
  - PREDICT_W=32.
- One sub-module, argmax_cmp_step: combinational. Inputs cur_max, cur_idx, first flag, new score, new idx. Outputs next max and index, using the signed >= rule. This keeps the compare rule identical to the parallel tree for cross-checking.

Test Plan:
- Scores {5,-3,100,7,0,99,-100,1,2,3}, out_ready=1 -> out_valid one cycle after beat 9, predict=32'd2, frames_done=1.
- All -50 except class 7 = -1 -> predict=7. Check sign handling: 0x1FFFFFFF beats 0x1FFFFFCE.
- Class 3 and 8 both 0x0FFFFFFF, rest 0 -> predict=8 (tie goes to later index).
- out_ready low 5 cycles after frame end -> out_valid held, predict stable, in_ready=0. After acceptance, in_ready=1 the next cycle and a second frame gives the correct independent result.
- Reset asserted after 4 beats, then a full frame with max at class 1 -> predict=1, frames_done=1; no stale max from the aborted frame.
- ERRCHK: in_last on beat 5 (idx 5), max at class 4 -> predict=4, frame_err=1. A correctly framed frame after it -> frame_err=0.
